// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the IF/MEM external SRAM arbiter.
// State and owner codes plus the SRAM address mapping.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_e;

  function automatic logic [17:0] ram_word(input logic [15:0] a);
    return {2'b00, a};
  endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the IF and MEM ports onto one 16-bit SRAM with
// fixed-length registered access sequences and one-cycle acks.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ACC_CYCLES     = 2,
  parameter int MAX_MEM_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_ack,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_ack,
  output logic [17:0] ram_addr,
  output logic [15:0] ram_dout,
  input  logic [15:0] ram_din,
  output logic        ram_dout_en,
  output logic        ram_ce_n,
  output logic        ram_oe_n,
  output logic        ram_we_n
);

  localparam int SW = $clog2(MAX_MEM_STREAK + 2);
  localparam logic [2:0] CNT_LAST = 3'(ACC_CYCLES - 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_MEM_STREAK);

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic          we_q, we_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [17:0]   addr_q, addr_d;
  logic [15:0]   dout_q, dout_d;
  logic          dout_en_q, dout_en_d;
  logic          ce_n_q, ce_n_d;
  logic          oe_n_q, oe_n_d;
  logic          we_n_q, we_n_d;
  logic          if_ack_q, if_ack_d;
  logic          mem_ack_q, mem_ack_d;
  logic [15:0]   if_rdata_q, if_rdata_d;
  logic [15:0]   mem_rdata_q, mem_rdata_d;
  logic          mem_win;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    streak_d    = streak_q;
    addr_d      = addr_q;
    dout_d      = dout_q;
    dout_en_d   = dout_en_q;
    ce_n_d      = ce_n_q;
    oe_n_d      = oe_n_q;
    we_n_d      = we_n_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    mem_win     = 1'b0;
    case (state_q)
      IDLE: begin
        addr_d    = '0;
        dout_d    = '0;
        dout_en_d = 1'b0;
        ce_n_d    = 1'b1;
        oe_n_d    = 1'b1;
        we_n_d    = 1'b1;
        if (if_req || mem_req) begin
          // a starved IF port is forced through once the streak saturates
          mem_win   = mem_req && !(if_req && streak_q == STREAK_MAX);
          owner_d   = mem_win ? OWN_MEM : OWN_IF;
          we_d      = mem_win && mem_we;
          streak_d  = (mem_win && if_req) ? streak_q + SW'(1) : '0;
          addr_d    = ram_word(mem_win ? mem_addr : if_addr);
          dout_d    = (mem_win && mem_we) ? mem_wdata : '0;
          dout_en_d = mem_win && mem_we;
          ce_n_d    = 1'b0;
          oe_n_d    = mem_win && mem_we;
          cnt_d     = '0;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          state_d   = ACK;
          ce_n_d    = 1'b1;
          oe_n_d    = 1'b1;
          we_n_d    = 1'b1;
          if_ack_d  = (owner_q == OWN_IF);
          mem_ack_d = (owner_q == OWN_MEM);
          if (!we_q) begin
            if (owner_q == OWN_MEM) mem_rdata_d = ram_din;
            else                    if_rdata_d  = ram_din;
          end
        end else begin
          cnt_d  = cnt_q + 3'd1;
          we_n_d = !we_q;
        end
      end
      ACK: begin
        state_d   = IDLE;
        addr_d    = '0;
        dout_d    = '0;
        dout_en_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      streak_q    <= '0;
      addr_q      <= '0;
      dout_q      <= '0;
      dout_en_q   <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      streak_q    <= streak_d;
      addr_q      <= addr_d;
      dout_q      <= dout_d;
      dout_en_q   <= dout_en_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign ram_addr    = addr_q;
  assign ram_dout    = dout_q;
  assign ram_dout_en = dout_en_q;
  assign ram_ce_n    = ce_n_q;
  assign ram_oe_n    = oe_n_q;
  assign ram_we_n    = we_n_q;
  assign if_ack      = if_ack_q;
  assign mem_ack     = mem_ack_q;
  assign if_rdata    = if_rdata_q;
  assign mem_rdata   = mem_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: vector table, corner sequences
// and a randomized run against a transaction-level model.
module tb_mem_bus_arbiter;

  localparam int ACC  = 2;
  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_ack;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic [17:0] ram_addr;
  logic [15:0] ram_dout;
  logic [15:0] ram_din;
  logic        ram_dout_en;
  logic        ram_ce_n;
  logic        ram_oe_n;
  logic        ram_we_n;

  mem_bus_arbiter #(
    .ACC_CYCLES    (ACC),
    .MAX_MEM_STREAK(MAXS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rdata   (if_rdata),
    .if_ack     (if_ack),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .ram_addr   (ram_addr),
    .ram_dout   (ram_dout),
    .ram_din    (ram_din),
    .ram_dout_en(ram_dout_en),
    .ram_ce_n   (ram_ce_n),
    .ram_oe_n   (ram_oe_n),
    .ram_we_n   (ram_we_n)
  );

  always #5 clk = ~clk;

  // 256-word SRAM behind the pins (upper address bits alias)
  logic [15:0] sram [0:255];
  logic [15:0] model_mem [0:255];
  assign ram_din = ram_oe_n ? 16'h0000 : sram[ram_addr[7:0]];
  always @(posedge clk)
    if (!ram_ce_n && !ram_we_n && ram_dout_en)
      sram[ram_addr[7:0]] <= ram_dout;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic do_txn(input bit is_mem, input bit we,
                        input logic [15:0] addr,
                        input logic [15:0] wd,
                        input logic [15:0] exp_rd,
                        input string nm);
    if (is_mem) begin
      mem_req = 1'b1; mem_we = we;
      mem_addr = addr; mem_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    for (int k = 0; k <= ACC; k++) begin
      tick();
      if (k < ACC) begin
        chk({nm, "_ce_n"}, ram_ce_n, 0);
        chk({nm, "_oe_n"}, ram_oe_n, we);
        chk({nm, "_we_n"}, ram_we_n, (we && k >= 1) ? 0 : 1);
        chk({nm, "_addr"}, ram_addr, {2'b00, addr});
        chk({nm, "_dout_en"}, ram_dout_en, we);
        if (we) chk({nm, "_dout"}, ram_dout, wd);
        chk({nm, "_early_ack"}, {if_ack, mem_ack}, 0);
      end else begin
        chk({nm, "_ack_strobes"},
            {ram_ce_n, ram_oe_n, ram_we_n}, 3'b111);
        chk({nm, "_ack"}, {if_ack, mem_ack},
            is_mem ? 2'b01 : 2'b10);
        if (we) begin
          chk({nm, "_hold_en"}, ram_dout_en, 1);
          chk({nm, "_hold_addr"}, ram_addr, {2'b00, addr});
          chk({nm, "_hold_dout"}, ram_dout, wd);
          model_mem[addr[7:0]] = wd;
        end else if (is_mem) begin
          chk({nm, "_rdata"}, mem_rdata, exp_rd);
        end else begin
          chk({nm, "_rdata"}, if_rdata, exp_rd);
        end
      end
    end
    if_req = 1'b0;
    mem_req = 1'b0;
    tick();
    chk({nm, "_post_ack"}, {if_ack, mem_ack}, 0);
    chk({nm, "_post_rel"}, {ram_dout_en, ram_ce_n}, 2'b01);
  endtask

  typedef struct {
    bit          is_mem;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
  } vec_t;

  // transaction-level model state for the random run
  bit          ip, mp, mwe;
  logic [15:0] ia, ma, mwd;
  int          free_at, streak;
  bit          busy, own_mem, own_we;
  int          ack_edge;
  logic [15:0] exp_data;

  task automatic rand_step(input bit allow_new);
    bit mw;
    if (allow_new && !ip && $urandom_range(0, 99) < 30) begin
      ip = 1'b1; ia = 16'($urandom);
      if_req = 1'b1; if_addr = ia;
    end
    if (allow_new && !mp && $urandom_range(0, 99) < 30) begin
      mp = 1'b1; ma = 16'($urandom);
      mwe = 1'($urandom); mwd = 16'($urandom);
      mem_req = 1'b1; mem_we = mwe;
      mem_addr = ma; mem_wdata = mwd;
    end
    if (!busy && (cyc + 1) >= free_at && (ip || mp)) begin
      mw = mp && !(ip && streak == MAXS);
      streak = (mw && ip) ? streak + 1 : 0;
      busy = 1'b1;
      own_mem = mw;
      own_we = mw && mwe;
      ack_edge = cyc + 1 + ACC;
      free_at = cyc + 1 + ACC + 2;
      if (mw) begin
        exp_data = model_mem[ma[7:0]];
        if (mwe) model_mem[ma[7:0]] = mwd;
      end else begin
        exp_data = model_mem[ia[7:0]];
      end
    end
    tick();
    chk("rnd_if_ack", if_ack,
        busy && !own_mem && cyc == ack_edge);
    chk("rnd_mem_ack", mem_ack,
        busy && own_mem && cyc == ack_edge);
    if (busy && cyc == ack_edge) begin
      if (own_mem) begin
        if (!own_we) chk("rnd_mem_rdata", mem_rdata, exp_data);
        mp = 1'b0; mem_req = 1'b0;
      end else begin
        chk("rnd_if_rdata", if_rdata, exp_data);
        ip = 1'b0; if_req = 1'b0;
      end
      busy = 1'b0;
    end
  endtask

  vec_t vecs [7];
  int   order [$];
  int   m_at, i_at, m_n, i_n, start;

  initial begin
    for (int i = 0; i < 256; i++) begin
      sram[i] = 16'h1000 + 16'(i);
      model_mem[i] = 16'h1000 + 16'(i);
    end
    sram[8'h10] = 16'h4A55;
    model_mem[8'h10] = 16'h4A55;

    vecs[0] = '{0, 0, 16'h0010, 16'h0000, 16'h4A55};
    vecs[1] = '{1, 1, 16'h8000, 16'hBEEF, 16'h0000};
    vecs[2] = '{1, 0, 16'h8000, 16'h0000, 16'hBEEF};
    vecs[3] = '{0, 0, 16'h0022, 16'h0000, 16'h1022};
    vecs[4] = '{1, 1, 16'h0033, 16'h1234, 16'h0000};
    vecs[5] = '{0, 0, 16'h0033, 16'h0000, 16'h1234};
    vecs[6] = '{1, 0, 16'h00FF, 16'h0000, 16'h10FF};

    rst = 1'b1; if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0;
    mem_addr = '0; mem_wdata = '0;
    tick();
    tick();
    chk("rst_strobes", {ram_ce_n, ram_oe_n, ram_we_n}, 3'b111);
    chk("rst_dout", {ram_dout_en, ram_dout}, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_acks", {if_ack, mem_ack}, 0);
    chk("rst_rdata", {if_rdata, mem_rdata}, 0);
    rst = 1'b0;
    tick();
    chk("idle_strobes", {ram_ce_n, ram_oe_n, ram_we_n}, 3'b111);

    for (int v = 0; v < 7; v++)
      do_txn(vecs[v].is_mem, vecs[v].we, vecs[v].addr,
             vecs[v].wdata, vecs[v].exp_rd, $sformatf("vec%0d", v));

    // simultaneous requests: MEM first, IF four cycles later
    reset_dut();
    if_req = 1'b1; if_addr = 16'h0010;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h0022;
    start = cyc; m_at = -1; i_at = -1; m_n = 0; i_n = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("sim_excl", if_ack & mem_ack, 0);
      if (mem_ack) begin
        m_n++; if (m_at < 0) m_at = cyc; mem_req = 1'b0;
      end
      if (if_ack) begin
        i_n++; if (i_at < 0) i_at = cyc; if_req = 1'b0;
      end
    end
    chk("sim_mem_lat", m_at - start, ACC + 1);
    chk("sim_if_gap", i_at - m_at, ACC + 2);
    chk("sim_pulses", {m_n[7:0], i_n[7:0]}, 16'h0101);
    chk("sim_if_rdata", if_rdata, 16'h4A55);
    chk("sim_mem_rdata", mem_rdata, 16'h1022);

    // starvation guard: MEM x4 then IF, repeating
    reset_dut();
    if_req = 1'b1; if_addr = 16'h0010;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h0022;
    order.delete();
    for (int k = 0; k < 100 && order.size() < 10; k++) begin
      tick();
      chk("streak_excl", if_ack & mem_ack, 0);
      if (mem_ack) order.push_back(1);
      if (if_ack) order.push_back(0);
    end
    chk("streak_count", order.size(), 10);
    for (int i = 0; i < order.size(); i++)
      chk($sformatf("streak_order%0d", i), order[i],
          (i % 5 == 4) ? 0 : 1);
    if_req = 1'b0; mem_req = 1'b0;
    tick(); tick();

    // reset in the second ACCESS cycle of a MEM read
    reset_dut();
    do_txn(1, 0, 16'h0022, 16'h0000, 16'h1022, "pre_rst_rd");
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h00FF;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_strobes", {ram_ce_n, ram_oe_n, ram_we_n}, 3'b111);
    chk("mid_rst_ack", mem_ack, 0);
    chk("mid_rst_rdata", mem_rdata, 0);
    rst = 1'b0; mem_req = 1'b0;
    tick();
    chk("mid_rst_no_ack", {if_ack, mem_ack}, 0);
    do_txn(0, 0, 16'h0010, 16'h0000, 16'h4A55, "post_rst_if");

    // request dropped right after grant still completes
    mem_req = 1'b1; mem_we = 1'b1;
    mem_addr = 16'h0044; mem_wdata = 16'h5555;
    tick();
    mem_req = 1'b0;
    m_n = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (mem_ack) m_n++;
    end
    chk("drop_ack_pulses", m_n, 1);
    model_mem[8'h44] = 16'h5555;
    do_txn(1, 0, 16'h0044, 16'h0000, 16'h5555, "drop_readback");

    // randomized run against the transaction-level model
    if_req = 1'b0; mem_req = 1'b0;
    reset_dut();
    ip = 0; mp = 0; busy = 0; streak = 0;
    free_at = cyc + 1; ack_edge = 0;
    for (int n = 0; n < 1500; n++) rand_step(1'b1);
    for (int n = 0; n < 40 && (ip || mp); n++) rand_step(1'b0);
    chk("rnd_drain", {ip, mp}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
